// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with forwarding operand mux and load-use stall request (option: EX_FORWARD_EN)
//
// Holds the instruction issued from ID for one EX cycle and presents the ALU
// operands. With EX_FORWARD_EN defined the source operands are taken from the
// EX/MEM or MEM/WB producers when they target the same register. Without it
// the stored register-file values are always used, and any RAW dependency on
// an instruction still in EX or EX/MEM raises hazard_stall instead.

module ex_operand_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic [W-1:0] id_rs_data,
  input  logic [W-1:0] id_rt_data,
  input  logic [W-1:0] id_imm,
  input  logic [4:0]   id_shamt,
  input  logic [3:0]   id_aluc,
  input  logic         id_a_sel,
  input  logic         id_b_sel,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         exm_reg_write,
  input  logic [4:0]   exm_rd,
  input  logic [W-1:0] exm_result,
  input  logic         mwb_reg_write,
  input  logic [4:0]   mwb_rd,
  input  logic [W-1:0] mwb_result,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_aluc,
  output logic         ex_valid,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic [4:0]   ex_rd,
  output logic [W-1:0] ex_store_data,
  output logic         hazard_stall
);

  // EX register contents
  logic         valid_q;
  logic [4:0]   rs_q;
  logic [4:0]   rt_q;
  logic [4:0]   rd_q;
  logic [W-1:0] rs_data_q;
  logic [W-1:0] rt_data_q;
  logic [W-1:0] imm_q;
  logic [4:0]   shamt_q;
  logic [3:0]   aluc_q;
  logic         a_sel_q;
  logic         b_sel_q;
  logic         reg_write_q;
  logic         mem_read_q;
  logic         mem_write_q;

  // Resolved source operand values
  logic [W-1:0] fwd_rs;
  logic [W-1:0] fwd_rt;

  // Hazard terms
  logic         load_use;
  logic         raw_stall;

  // EX register: reset, then flush (bubble), then stall (refresh data only), then load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      aluc_q      <= '0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      aluc_q      <= '0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (stall) begin
      // Capture forwarded values so a producer retiring during the stall
      // is still seen once it has left the pipeline.
      rs_data_q   <= fwd_rs;
      rt_data_q   <= fwd_rt;
    end else begin
      valid_q     <= id_valid;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rd_q        <= id_rd;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      shamt_q     <= id_shamt;
      aluc_q      <= id_aluc;
      a_sel_q     <= id_a_sel;
      b_sel_q     <= id_b_sel;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

`ifdef EX_FORWARD_EN
  // Operand forwarding: EX/MEM beats MEM/WB, register $0 is never forwarded
  always_comb begin
    fwd_rs = rs_data_q;
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rs_q)) begin
      fwd_rs = exm_result;
    end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == rs_q)) begin
      fwd_rs = mwb_result;
    end

    fwd_rt = rt_data_q;
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rt_q)) begin
      fwd_rt = exm_result;
    end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == rt_q)) begin
      fwd_rt = mwb_result;
    end
  end

  assign raw_stall = 1'b0;
`else
  // No forwarding network: operands come straight from the register file
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
  end

  // Without forwarding, wait until an in-flight producer reaches MEM/WB,
  // where the register file's write-before-read covers the dependency.
  always_comb begin
    raw_stall = 1'b0;
    if (id_valid && (id_rs != 5'd0)) begin
      if (valid_q && reg_write_q && (rd_q == id_rs)) raw_stall = 1'b1;
      if (exm_reg_write && (exm_rd == id_rs))        raw_stall = 1'b1;
    end
    if (id_valid && (id_rt != 5'd0)) begin
      if (valid_q && reg_write_q && (rd_q == id_rt)) raw_stall = 1'b1;
      if (exm_reg_write && (exm_rd == id_rt))        raw_stall = 1'b1;
    end
  end

  // Producer data and MEM/WB tags are not needed when forwarding is off
  logic unused_fwd;
  assign unused_fwd = ^{exm_result, mwb_reg_write, mwb_rd, mwb_result, rs_q, rt_q};
`endif

  // Load-use: a load in EX cannot forward its data in time for ID's consumer
  always_comb begin
    load_use = valid_q && mem_read_q && (rd_q != 5'd0) && id_valid &&
               ((rd_q == id_rs) || (rd_q == id_rt));
  end

  assign hazard_stall = load_use || raw_stall;

  // ALU operand drive: shift amount goes on a, immediate optionally on b
  always_comb begin
    alu_a = a_sel_q ? {{(W-5){1'b0}}, shamt_q} : fwd_rs;
    alu_b = b_sel_q ? imm_q : fwd_rt;
  end

  assign alu_aluc      = aluc_q;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_rd         = rd_q;

endmodule
